// File: rtl/ushreg_pkg.sv
// Shared mode encodings for the universal shift register.
// Mode 110 is ASR only when USHREG_ASR_EN is defined.
package ushreg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

endpackage : ushreg_pkg

// File: rtl/ushreg_counter.sv
// Saturating 0..N shift counter with synchronous clear and async active-low reset.
module ushreg_counter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Sync clear wins over increment; increment stops at N.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(N))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CW'(N));

endmodule : ushreg_counter

// File: rtl/n_universal_shreg.sv
// N-bit universal shift register: hold/load/shift/rotate/clear with shift counter.
// Define USHREG_ASR_EN to make mode 110 an arithmetic shift right (else HOLD).
module n_universal_shreg
  import ushreg_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [N-1:0]      q,
  output logic              sout_l,
  output logic              sout_r,
  output logic [CW-1:0]     cnt,
  output logic              done
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         cnt_inc;
  logic         cnt_clr;

  // Next-state mux; en low freezes both q and the counter, whatever the mode.
  always_comb begin
    q_d     = q_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          q_d     = d;
          cnt_clr = 1'b1;
        end
        MODE_SHL: begin
          q_d     = {q_q[N-2:0], sin_r};
          cnt_inc = 1'b1;
        end
        MODE_SHR: begin
          q_d     = {sin_l, q_q[N-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_ROL: begin
          q_d     = {q_q[N-2:0], q_q[N-1]};
          cnt_inc = 1'b1;
        end
        MODE_ROR: begin
          q_d     = {q_q[0], q_q[N-1:1]};
          cnt_inc = 1'b1;
        end
`ifdef USHREG_ASR_EN
        MODE_ASR: begin
          q_d     = {q_q[N-1], q_q[N-1:1]};
          cnt_inc = 1'b1;
        end
`endif
        MODE_CLR: begin
          q_d     = '0;
          cnt_clr = 1'b1;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  ushreg_counter #(.N(N)) u_counter (
    .clk   (clk),
    .clear (clear),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .done  (done)
  );

  assign q      = q_q;
  assign sout_l = q_q[N-1];
  assign sout_r = q_q[0];

endmodule : n_universal_shreg
